// File: rtl/pipe_reg_skid_if.sv
// Handshake bundle for pipe_reg_skid: upstream payload/valid/ready,
// downstream payload/valid/ready, flush and status outputs.
interface pipe_reg_skid_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int CNT_W  = 16
);
    logic [PC_W-1:0]   PC_in_PRS;
    logic [INST_W-1:0] inst_in_PRS;
    logic              valid_in_PRS;
    logic              ready_out_PRS;
    logic              flush_PRS;
    logic [PC_W-1:0]   PC_out_PRS;
    logic [INST_W-1:0] inst_out_PRS;
    logic              valid_out_PRS;
    logic              ready_in_PRS;
    logic [1:0]        occ_PRS;
    logic [CNT_W-1:0]  stall_cnt_PRS;

    // Side that owns the register slice.
    modport slave (
        input  PC_in_PRS, inst_in_PRS, valid_in_PRS, flush_PRS, ready_in_PRS,
        output ready_out_PRS, PC_out_PRS, inst_out_PRS, valid_out_PRS,
               occ_PRS, stall_cnt_PRS
    );

    // Side that drives payloads in and consumes them out.
    modport master (
        output PC_in_PRS, inst_in_PRS, valid_in_PRS, flush_PRS, ready_in_PRS,
        input  ready_out_PRS, PC_out_PRS, inst_out_PRS, valid_out_PRS,
               occ_PRS, stall_cnt_PRS
    );
endinterface

// File: rtl/pipe_reg_skid.sv
// Two-entry skid-buffered pipeline register for a PC/instruction pair.
// MAIN drives the outputs; SKID absorbs one payload when downstream stalls,
// so upstream ready depends only on registered state.
module pipe_reg_skid #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
    parameter int                CNT_W    = 16
) (
    input  logic           clk_PRS,
    input  logic           rst_PRS,
    pipe_reg_skid_if.slave bus
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic              valid_r;
    logic              ready_r;
    logic [PC_W-1:0]   main_pc_r;
    logic [INST_W-1:0] main_inst_r;
    logic [PC_W-1:0]   skid_pc_r;
    logic [INST_W-1:0] skid_inst_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic in_fire_s;
    logic out_fire_s;
    logic load_main_s;
    logic load_skid_s;
    logic skid_to_main_s;
    logic clear_main_s;

    assign in_fire_s  = bus.valid_in_PRS & ready_r;
    assign out_fire_s = valid_r & bus.ready_in_PRS;

    // Next-state and datapath steering for the EMPTY/BUSY/FULL machine.
    always_comb begin
        state_nxt_s    = state_r;
        load_main_s    = 1'b0;
        load_skid_s    = 1'b0;
        skid_to_main_s = 1'b0;
        clear_main_s   = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    load_main_s = 1'b1;
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (in_fire_s && out_fire_s) begin
                    load_main_s = 1'b1;
                    state_nxt_s = ST_BUSY;
                end else if (in_fire_s) begin
                    load_skid_s = 1'b1;
                    state_nxt_s = ST_FULL;
                end else if (out_fire_s) begin
                    clear_main_s = 1'b1;
                    state_nxt_s  = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_FULL: begin
                // Inputs are ignored here: ready_out is low in FULL.
                if (out_fire_s) begin
                    skid_to_main_s = 1'b1;
                    state_nxt_s    = ST_BUSY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                clear_main_s = 1'b1;
                state_nxt_s  = ST_EMPTY;
            end
        endcase
    end

    // State, registered handshake outputs and payload registers; reset beats flush beats handshakes.
    always_ff @(posedge clk_PRS) begin
        if (rst_PRS || bus.flush_PRS) begin
            state_r     <= ST_EMPTY;
            valid_r     <= 1'b0;
            ready_r     <= 1'b1;
            main_pc_r   <= {PC_W{1'b0}};
            main_inst_r <= NOP_INST;
            skid_pc_r   <= {PC_W{1'b0}};
            skid_inst_r <= {INST_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s != ST_EMPTY);
            ready_r <= (state_nxt_s != ST_FULL);
            // Idle MAIN holds the bubble so outputs are clean whenever not valid.
            if (load_main_s) begin
                main_pc_r   <= bus.PC_in_PRS;
                main_inst_r <= bus.inst_in_PRS;
            end else if (skid_to_main_s) begin
                main_pc_r   <= skid_pc_r;
                main_inst_r <= skid_inst_r;
            end else if (clear_main_s) begin
                main_pc_r   <= {PC_W{1'b0}};
                main_inst_r <= NOP_INST;
            end else begin
                main_pc_r   <= main_pc_r;
                main_inst_r <= main_inst_r;
            end
            if (load_skid_s) begin
                skid_pc_r   <= bus.PC_in_PRS;
                skid_inst_r <= bus.inst_in_PRS;
            end else begin
                skid_pc_r   <= skid_pc_r;
                skid_inst_r <= skid_inst_r;
            end
        end
    end

    // Saturating count of cycles where a valid output was back-pressured; flush does not touch it.
    always_ff @(posedge clk_PRS) begin
        if (rst_PRS) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (valid_r && !bus.ready_in_PRS && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.ready_out_PRS = ready_r;
    assign bus.valid_out_PRS = valid_r;
    assign bus.PC_out_PRS    = main_pc_r;
    assign bus.inst_out_PRS  = main_inst_r;
    assign bus.occ_PRS       = state_r;
    assign bus.stall_cnt_PRS = stall_cnt_r;
endmodule

// File: tb/tb_pipe_reg_skid.sv
// Scoreboard bench for pipe_reg_skid: a queue model of the held payloads
// predicts every output each cycle; a second CNT_W=4 instance covers
// stall-counter saturation.
module tb_pipe_reg_skid;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_reg_skid_if #(.PC_W(32), .INST_W(32), .CNT_W(16)) bus ();
    pipe_reg_skid_if #(.PC_W(32), .INST_W(32), .CNT_W(4))  sbus ();

    pipe_reg_skid #(.PC_W(32), .INST_W(32), .NOP_INST(32'h00000013), .CNT_W(16)) u_dut (
        .clk_PRS(clk), .rst_PRS(rst), .bus(bus)
    );
    pipe_reg_skid #(.PC_W(32), .INST_W(32), .NOP_INST(32'h00000013), .CNT_W(4)) u_sat (
        .clk_PRS(clk), .rst_PRS(rst), .bus(sbus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } pl_t;

    pl_t         exp_q[$];
    int unsigned model_cnt;
    int          errors = 0;
    int          checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl);
        bus.valid_in_PRS = v;
        bus.PC_in_PRS    = pc;
        bus.inst_in_PRS  = inst;
        bus.ready_in_PRS = rdy;
        bus.flush_PRS    = fl;
    endtask

    // Compare outputs against the model mid-cycle, then advance the model on the edge.
    task automatic cycle();
        int  sz;
        logic of, inf;
        pl_t p;
        @(negedge clk);
        sz = exp_q.size();
        check_eq("occ", bus.occ_PRS, sz);
        check_eq("ready_out", bus.ready_out_PRS, (sz < 2));
        check_eq("valid_out", bus.valid_out_PRS, (sz > 0));
        check_eq("pc_out", bus.PC_out_PRS, (sz > 0) ? exp_q[0].pc : 32'h0);
        check_eq("inst_out", bus.inst_out_PRS, (sz > 0) ? exp_q[0].inst : NOP);
        check_eq("stall_cnt", bus.stall_cnt_PRS, model_cnt);
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            of  = (sz > 0) && bus.ready_in_PRS;
            inf = bus.valid_in_PRS && (sz < 2);
            if ((sz > 0) && !bus.ready_in_PRS && (model_cnt < 65535)) model_cnt++;
            if (bus.flush_PRS) begin
                exp_q.delete();
            end else begin
                if (of) void'(exp_q.pop_front());
                if (inf) begin
                    p.pc   = bus.PC_in_PRS;
                    p.inst = bus.inst_in_PRS;
                    exp_q.push_back(p);
                end
            end
        end
        #1;
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        sbus.valid_in_PRS = 1'b0;
        sbus.PC_in_PRS    = 32'h0;
        sbus.inst_in_PRS  = 32'h0;
        sbus.ready_in_PRS = 1'b1;
        sbus.flush_PRS    = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        model_cnt = 0;
        rst = 1'b0;

        // Reset state.
        cycle();

        // Streaming at full rate.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 32'hA000_0000 | 32'(i), 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (2) cycle();

        // Back-pressure: fill to FULL, hold off 0x108, then drain in order.
        drive(1'b1, 32'h100, 32'hB100, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h104, 32'hB104, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h108, 32'hB108, 1'b0, 1'b0); repeat (2) cycle();
        drive(1'b1, 32'h108, 32'hB108, 1'b1, 1'b0); repeat (2) cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);      repeat (2) cycle();
        check_eq("bp_stall_total", bus.stall_cnt_PRS, 16'd3);

        // Flush while FULL with a valid input that must be dropped.
        drive(1'b1, 32'h1F0, 32'hC1F0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h1F4, 32'hC1F4, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h200, 32'hC200, 1'b0, 1'b1); cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);      repeat (2) cycle();

        // Reset while FULL, then one payload with one-cycle latency.
        drive(1'b1, 32'h2F0, 32'hD2F0, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h2F4, 32'hD2F4, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h300, 32'hD300, 1'b0, 1'b0);
        rst = 1'b1; cycle(); rst = 1'b0;
        drive(1'b1, 32'h310, 32'hD310, 1'b1, 1'b0); cycle();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);      repeat (2) cycle();

        // Random valid/ready/flush traffic.
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
            cycle();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (3) cycle();

        // Saturation on the 4-bit counter instance.
        sbus.valid_in_PRS = 1'b1;
        sbus.PC_in_PRS    = 32'h400;
        sbus.inst_in_PRS  = 32'hE400;
        sbus.ready_in_PRS = 1'b0;
        @(posedge clk); #1;
        sbus.valid_in_PRS = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk); #1;
            check_eq("sat_cnt", sbus.stall_cnt_PRS, (k < 15) ? k : 15);
        end
        check_eq("sat_valid", sbus.valid_out_PRS, 1'b1);
        check_eq("sat_pc", sbus.PC_out_PRS, 32'h400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
